gmii_rx_deframer: RTL and testbench

// PHY-side receiver for the GMII transmit stream of the board's 1G MAC, used for loopback/diagnostic capture.
// - Input: gmii_txd/tx_en/tx_er routed to this block's gmii_rx* inputs.
// - Detects preamble/SFD, checks FCS, length and rx_er.
// - Emits the frame bytes after SFD, FCS stripped, as an 8-bit AXI-Stream with per-frame status pulses.
// - GMII cannot stall, so the output has no tready; the sink must accept every beat.

---
 rtl/gmii_rx_deframer.sv | 206 ++++++++++++++++++++
 tb/tb_gmii_rx_deframer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD and FCS, checks CRC/length/rx_er,
// and streams the frame body as 8-bit AXI-Stream with per-frame status pulses.
module gmii_rx_deframer #(
  parameter int unsigned MIN_FRAME_LENGTH = 64,
  parameter int unsigned MAX_FRAME_LENGTH = 1518
) (
  input  logic       clock125,
  input  logic       reset,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_good_frame,
  output logic       stat_bad_fcs,
  output logic       stat_runt,
  output logic       stat_oversize,
  output logic       stat_rx_error,
  output logic       stat_preamble_err
);

  localparam int unsigned CNT_W     = $clog2(MAX_FRAME_LENGTH + 2);
  localparam int unsigned WIN_DEPTH = 5;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

  state_t state_q, state_d;

  logic [7:0] rxd_r;
  logic       dv_r, er_r;

  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [31:0]                    crc_q, crc_d;
  logic [WIN_DEPTH-1:0][7:0]      win_q, win_d;
  logic                           err_seen_q, err_seen_d;
  logic                           line_busy_q;

  logic [7:0] tdata_d;
  logic       tvalid_d, tlast_d, tuser_d;
  logic       good_d, bad_fcs_d, runt_d, oversize_d, rx_error_d, preamble_err_d;
  logic       start_frame;

  logic fcs_bad, runt, have_beat, frame_bad;

  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Input capture stage; all decisions below use these copies.
  always_ff @(posedge clock125) begin
    rxd_r <= gmii_rxd;
    dv_r  <= gmii_rx_dv;
    er_r  <= gmii_rx_er;
  end

  assign fcs_bad   = (crc_q != CRC_RESIDUE);
  assign runt      = (cnt_q < CNT_W'(MIN_FRAME_LENGTH));
  assign have_beat = (cnt_q >= CNT_W'(WIN_DEPTH));
  assign frame_bad = fcs_bad | runt | err_seen_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    crc_d          = crc_q;
    win_d          = win_q;
    err_seen_d     = err_seen_q;
    start_frame    = 1'b0;
    tdata_d        = 8'h00;
    tvalid_d       = 1'b0;
    tlast_d        = 1'b0;
    tuser_d        = 1'b0;
    good_d         = 1'b0;
    bad_fcs_d      = 1'b0;
    runt_d         = 1'b0;
    oversize_d     = 1'b0;
    rx_error_d     = 1'b0;
    preamble_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A line already active out of reset is mid-frame: never deliver it.
        if (dv_r) begin
          if (line_busy_q) begin
            state_d = DROP;
          end else if (rxd_r == PRE_BYTE) begin
            state_d = PREAMBLE;
          end else if (rxd_r == SFD_BYTE) begin
            start_frame = 1'b1;
          end else begin
            state_d        = DROP;
            preamble_err_d = 1'b1;
          end
        end
      end

      PREAMBLE: begin
        if (!dv_r) begin
          state_d        = IDLE;
          preamble_err_d = 1'b1;
        end else if (er_r || (rxd_r != PRE_BYTE && rxd_r != SFD_BYTE)) begin
          state_d        = DROP;
          preamble_err_d = 1'b1;
        end else if (rxd_r == SFD_BYTE) begin
          start_frame = 1'b1;
        end
      end

      PAYLOAD: begin
        if (dv_r) begin
          cnt_d      = cnt_q + CNT_W'(1);
          crc_d      = crc_next(crc_q, rxd_r);
          win_d      = {win_q[WIN_DEPTH-2:0], rxd_r};
          err_seen_d = err_seen_q | er_r;
          if (have_beat) begin
            tvalid_d = 1'b1;
            tdata_d  = win_q[WIN_DEPTH-1];
          end
          // Byte MAX+1: close the frame early as bad without evaluating CRC.
          if (cnt_q == CNT_W'(MAX_FRAME_LENGTH)) begin
            tlast_d    = 1'b1;
            tuser_d    = 1'b1;
            oversize_d = 1'b1;
            rx_error_d = err_seen_q | er_r;
            state_d    = DROP;
          end
        end else begin
          state_d = IDLE;
          if (have_beat) begin
            tvalid_d = 1'b1;
            tdata_d  = win_q[WIN_DEPTH-1];
            tlast_d  = 1'b1;
            tuser_d  = frame_bad;
          end
          good_d     = ~frame_bad;
          bad_fcs_d  = fcs_bad;
          runt_d     = runt;
          rx_error_d = err_seen_q;
        end
      end

      DROP: begin
        if (!dv_r) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      state_d    = PAYLOAD;
      cnt_d      = '0;
      crc_d      = CRC_INIT;
      err_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clock125) begin
    if (reset) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      crc_q             <= CRC_INIT;
      win_q             <= '0;
      err_seen_q        <= 1'b0;
      line_busy_q       <= 1'b1;
      m_axis_tdata      <= 8'h00;
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser      <= 1'b0;
      stat_good_frame   <= 1'b0;
      stat_bad_fcs      <= 1'b0;
      stat_runt         <= 1'b0;
      stat_oversize     <= 1'b0;
      stat_rx_error     <= 1'b0;
      stat_preamble_err <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      crc_q             <= crc_d;
      win_q             <= win_d;
      err_seen_q        <= err_seen_d;
      line_busy_q       <= dv_r;
      m_axis_tdata      <= tdata_d;
      m_axis_tvalid     <= tvalid_d;
      m_axis_tlast      <= tlast_d;
      m_axis_tuser      <= tuser_d;
      stat_good_frame   <= good_d;
      stat_bad_fcs      <= bad_fcs_d;
      stat_runt         <= runt_d;
      stat_oversize     <= oversize_d;
      stat_rx_error     <= rx_error_d;
      stat_preamble_err <= preamble_err_d;
    end
  end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Scoreboard bench for gmii_rx_deframer: the driver queues expected beats/status
// with their due cycle; a negedge monitor pops and compares what the DUT emits.
module tb_gmii_rx_deframer;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rxd   = 8'h00;
  logic       dv    = 1'b0;
  logic       er    = 1'b0;

  logic [7:0] tdata;
  logic       tvalid, tlast, tuser;
  logic       s_good, s_fcs, s_runt, s_over, s_rxer, s_pre;

  gmii_rx_deframer #(.MIN_FRAME_LENGTH(MIN_LEN), .MAX_FRAME_LENGTH(MAX_LEN)) dut (
    .clock125(clk), .reset(reset),
    .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(er),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .stat_good_frame(s_good), .stat_bad_fcs(s_fcs), .stat_runt(s_runt),
    .stat_oversize(s_over), .stat_rx_error(s_rxer), .stat_preamble_err(s_pre)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; logic last; logic user; int cyc; } beat_t;
  typedef struct { logic [5:0] st; int cyc; } stat_t;

  beat_t      bq[$];
  stat_t      sq[$];
  logic [7:0] frm[$];

  int checks = 0;
  int errors = 0;
  bit chk_reset = 1'b0;
  bit do_final = 1'b0;
  bit final_done = 1'b0;
  int beat_no = 0;

  // Status vector order: good, bad_fcs, runt, oversize, rx_error, preamble_err
  localparam logic [5:0] ST_GOOD = 6'b100000;
  localparam logic [5:0] ST_FCS  = 6'b010000;
  localparam logic [5:0] ST_RUNT = 6'b001000;
  localparam logic [5:0] ST_OVER = 6'b000100;
  localparam logic [5:0] ST_RXER = 6'b000010;
  localparam logic [5:0] ST_PRE  = 6'b000001;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic make_frame(input int nd, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < nd; i++) begin
      b = 8'(i * 13 + seed * 29 + 7);
      frm.push_back(b);
      c = crc_byte(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic e);
    @(posedge clk);
    #1;
    rxd = d;
    dv  = v;
    er  = e;
  endtask

  // Called right after drive(): the response to that GMII cycle is due 2 cycles later.
  task automatic push_beat(input logic [7:0] d, input logic l, input logic u);
    beat_t b;
    b.d = d; b.last = l; b.user = u; b.cyc = cyc + 2;
    bq.push_back(b);
  endtask

  task automatic push_stat(input logic [5:0] st);
    stat_t s;
    s.st = st; s.cyc = cyc + 2;
    sq.push_back(s);
  endtask

  task automatic send_frame(input int pre, input int er_at, input logic [5:0] exp, input int gap);
    int n;
    for (int i = 0; i < pre; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    n = frm.size();
    for (int k = 1; k <= n; k++) begin
      drive(frm[k-1], 1'b1, k == er_at);
      if (k >= 6 && k <= MAX_LEN + 1) push_beat(frm[k-6], k == MAX_LEN + 1, k == MAX_LEN + 1);
      if (k == MAX_LEN + 1) push_stat(exp);
    end
    drive(8'h00, 1'b0, 1'b0);
    if (n <= MAX_LEN) begin
      if (n >= 5) push_beat(frm[n-5], 1'b1, exp != ST_GOOD);
      push_stat(exp);
    end
    for (int i = 1; i < gap; i++) drive(8'h00, 1'b0, (i % 2) == 1);
  endtask

  beat_t      mb;
  stat_t      ms;
  logic [5:0] st;

  always @(negedge clk) begin
    st = {s_good, s_fcs, s_runt, s_over, s_rxer, s_pre};
    if (chk_reset) begin
      checks++;
      if ({tdata, tvalid, tlast, tuser, st} != '0) begin
        errors++;
        $display("FAIL reset_outputs: got data=%02h v=%b l=%b u=%b stat=%b, expected all zero",
                 tdata, tvalid, tlast, tuser, st);
      end
    end
    if (!reset) begin
      while (bq.size() > 0 && bq[0].cyc < cyc) begin
        mb = bq.pop_front();
        checks++; errors++;
        $display("FAIL beat_missing: expected data %02h last=%b due cycle %0d, nothing by cycle %0d",
                 mb.d, mb.last, mb.cyc, cyc);
      end
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        ms = sq.pop_front();
        checks++; errors++;
        $display("FAIL stat_missing: expected stat %b due cycle %0d, nothing by cycle %0d",
                 ms.st, ms.cyc, cyc);
      end
      if (tvalid) begin
        checks++;
        beat_no++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got data %02h last=%b at cycle %0d, expected no beat",
                   tdata, tlast, cyc);
        end else begin
          mb = bq.pop_front();
          if (mb.cyc != cyc || mb.d != tdata || mb.last != tlast || (mb.last && mb.user != tuser)) begin
            errors++;
            $display("FAIL beat_%0d: got data=%02h last=%b user=%b cycle=%0d, expected data=%02h last=%b user=%b cycle=%0d",
                     beat_no, tdata, tlast, tuser, cyc, mb.d, mb.last, mb.user, mb.cyc);
          end
        end
      end
      if (st != 6'd0 || (tvalid && tlast)) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL stat_unexpected: got stat %b at cycle %0d, expected none", st, cyc);
        end else begin
          ms = sq.pop_front();
          if (ms.st != st || ms.cyc != cyc) begin
            errors++;
            $display("FAIL stat: got %b at cycle %0d, expected %b at cycle %0d", st, cyc, ms.st, ms.cyc);
          end
        end
      end
    end
    if (do_final && !final_done) begin
      final_done = 1'b1;
      checks += 2;
      if (bq.size() != 0) begin
        errors++;
        $display("FAIL beats_left: got %0d undelivered, expected 0", bq.size());
      end
      if (sq.size() != 0) begin
        errors++;
        $display("FAIL stats_left: got %0d undelivered, expected 0", sq.size());
      end
    end
  end

  initial begin
    repeat (3) drive(8'h00, 1'b0, 1'b0);
    chk_reset = 1'b1;
    drive(8'h00, 1'b0, 1'b0);
    chk_reset = 1'b0;
    reset = 1'b0;
    repeat (3) drive(8'h00, 1'b0, 1'b0);

    // Good 64-byte frame, then FCS corruption, runt, rx_er inside frame
    make_frame(60, 1);  send_frame(7, 0,  ST_GOOD, 12);
    make_frame(60, 2);  frm[61] = frm[61] ^ 8'h01; send_frame(7, 0, ST_FCS, 12);
    make_frame(16, 3);  send_frame(7, 0,  ST_RUNT, 12);
    make_frame(60, 4);  send_frame(7, 30, ST_RXER, 12);

    // Length boundaries: 63, 4 (no beats, valid FCS), 0 (SFD then dv drop)
    make_frame(59, 5);  send_frame(7, 0, ST_RUNT, 12);
    make_frame(0, 6);   send_frame(7, 0, ST_RUNT, 12);
    frm.delete();       send_frame(7, 0, ST_RUNT | ST_FCS, 12);

    // Bad preamble byte, then a good frame
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h5D, 1'b1, 1'b0); push_stat(ST_PRE);
    repeat (3) drive(8'h55, 1'b1, 1'b0);
    repeat (2) drive(8'h00, 1'b0, 1'b0);
    make_frame(60, 7);  send_frame(7, 0, ST_GOOD, 12);

    // dv drop inside preamble; junk first byte from idle
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0); push_stat(ST_PRE);
    repeat (3) drive(8'h00, 1'b0, 1'b0);
    drive(8'h12, 1'b1, 1'b0); push_stat(ST_PRE);
    repeat (4) drive(8'hD5, 1'b1, 1'b0);
    repeat (3) drive(8'h00, 1'b0, 1'b0);

    // SFD with no preamble
    make_frame(60, 14); send_frame(0, 0, ST_GOOD, 12);

    // Oversize and exactly-maximum frames
    make_frame(1596, 8); send_frame(7, 0, ST_OVER, 12);
    make_frame(1514, 9); send_frame(7, 0, ST_GOOD, 12);

    // Back-to-back good frames with a single idle cycle
    make_frame(60, 10); send_frame(7, 0, ST_GOOD, 1);
    make_frame(60, 11); send_frame(7, 0, ST_GOOD, 12);

    // Reset mid-payload with dv held high through release
    make_frame(60, 12);
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) drive(frm[k], 1'b1, 1'b0);
    drive(frm[3], 1'b1, 1'b0); reset = 1'b1;
    drive(frm[4], 1'b1, 1'b0);
    drive(frm[5], 1'b1, 1'b0); reset = 1'b0;
    for (int k = 6; k < 64; k++) drive(frm[k], 1'b1, 1'b0);
    repeat (3) drive(8'h00, 1'b0, 1'b0);
    make_frame(60, 13); send_frame(7, 0, ST_GOOD, 12);

    repeat (10) drive(8'h00, 1'b0, 1'b0);
    do_final = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
